qsort_sched: RTL

QSORT_SCHED -- requirements
Module: qsort_sched

---
 rtl/qsort_sched_if.sv | 24 ++
 rtl/qsort_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qsort_sched_if.sv
// Requester-facing bundle of the sort scheduler: job request/grant, load stream
// and result stream for two requesters.
interface qsort_sched_if #(
  parameter int DW = 32
);
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic [2*DW-1:0] s_data;
  logic [1:0]      s_valid;
  logic [1:0]      s_ready;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_valid;
  logic [1:0]      m_ready;

  modport master (
    output req, s_data, s_valid, m_ready,
    input  gnt, s_ready, m_data, m_valid
  );

  modport slave (
    input  req, s_data, s_valid, m_ready,
    output gnt, s_ready, m_data, m_valid
  );
endinterface

// File: rtl/qsort_sched.sv
// Two-requester scheduler for a shared external sorter: grants jobs round-robin, streams
// a job into the sorter, captures the sorted words and drains them back to the owner.
// Optional load watchdog enabled by defining QSORT_SCHED_TIMEOUT_EN.
module qsort_sched #(
  parameter int DW       = 32,
  parameter int N_ELEM   = 10,
  parameter int SORT_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  qsort_sched_if.slave  bus,
  output logic [DW-1:0] acc_data_o,
  output logic          acc_data_valid,
  output logic          func_sel,
  output logic          sort_clr,
  input  logic [DW-1:0] sort_data_i,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(N_ELEM + 1);
  localparam int LW = $clog2(SORT_LAT + 1);
  localparam logic [CW-1:0] LAST     = CW'(N_ELEM - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(SORT_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, CAPT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          rr_ptr, rr_d;
  logic [CW-1:0] beat_cnt;
  logic [LW-1:0] lat_cnt;
  logic [CW-1:0] cap_idx;
  logic [CW-1:0] rd_idx;
  logic [DW-1:0] sbuf [N_ELEM];

  logic          g;
  logic          pick;
  logic [DW-1:0] s_sel;
  logic          beat;
  logic          drain_hs;
  logic          err_c;

  // Granted requester index; gnt_q is one-hot while a job is active.
  assign g        = gnt_q[1];
  assign pick     = bus.req[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign s_sel    = g ? bus.s_data[2*DW-1:DW] : bus.s_data[DW-1:0];
  assign beat     = (state_q == LOAD) && bus.s_valid[g];
  assign drain_hs = (state_q == DRAIN) && bus.m_ready[g];
  assign bus.gnt  = gnt_q;
  assign busy     = (state_q != IDLE);

`ifdef QSORT_SCHED_TIMEOUT_EN
  localparam logic [7:0] WDOG_MAX = 8'hFF;
  logic [7:0] wdog;
  assign err = err_c;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_d           = rr_ptr;
    bus.s_ready    = 2'b00;
    bus.m_valid    = 2'b00;
    bus.m_data     = '0;
    acc_data_o     = '0;
    acc_data_valid = 1'b0;
    func_sel       = 1'b0;
    sort_clr       = 1'b0;
    done           = 1'b0;
    err_c          = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = CLR;
        end
      end
      CLR: begin
        sort_clr = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        func_sel    = 1'b1;
        bus.s_ready = gnt_q;
        if (beat) begin
          acc_data_o     = s_sel;
          acc_data_valid = 1'b1;
          if (beat_cnt == LAST) state_d = WAIT;
        end
`ifdef QSORT_SCHED_TIMEOUT_EN
        else if (wdog == WDOG_MAX) begin
          // Stalled loader: flush the sorter and hand the slot to the other requester.
          err_c    = 1'b1;
          sort_clr = 1'b1;
          gnt_d    = 2'b00;
          rr_d     = ~g;
          state_d  = IDLE;
        end
`endif
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) state_d = CAPT;
      end
      CAPT: begin
        if (cap_idx == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        bus.m_valid = gnt_q;
        bus.m_data  = sbuf[rd_idx];
        if (drain_hs && (rd_idx == LAST)) begin
          done    = 1'b1;
          gnt_d   = 2'b00;
          rr_d    = ~g;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      rr_ptr  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_ptr  <= rr_d;
    end
  end

  // Each counter restarts when its state is entered and saturates at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      lat_cnt  <= '0;
      cap_idx  <= '0;
      rd_idx   <= '0;
    end else begin
      if (state_d == LOAD && state_q != LOAD)
        beat_cnt <= '0;
      else if (beat && beat_cnt != LAST)
        beat_cnt <= beat_cnt + 1'b1;

      if (state_d == WAIT && state_q != WAIT)
        lat_cnt <= '0;
      else if (state_q == WAIT && lat_cnt != LAT_LAST)
        lat_cnt <= lat_cnt + 1'b1;

      if (state_d == CAPT && state_q != CAPT)
        cap_idx <= '0;
      else if (state_q == CAPT && cap_idx != LAST)
        cap_idx <= cap_idx + 1'b1;

      if (state_d == DRAIN && state_q != DRAIN)
        rd_idx <= '0;
      else if (drain_hs && rd_idx != LAST)
        rd_idx <= rd_idx + 1'b1;
    end
  end

`ifdef QSORT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wdog <= '0;
    else if ((state_d == LOAD && state_q != LOAD) || beat)
      wdog <= '0;
    else if (state_q == LOAD && wdog != WDOG_MAX)
      wdog <= wdog + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (state_q == CAPT)
      sbuf[cap_idx] <= sort_data_i;
  end

endmodule
